// File: rtl/fir_rr_scheduler.sv
// Round-robin front end that shares one FIR instance between NUM_CH sample sources.
// Each accepted beat carries its channel tag through a FIR_LATENCY-deep line so results leave tagged.
module fir_rr_scheduler #(
  parameter  int NUM_CH      = 4,
  parameter  int DIN_W       = 16,
  parameter  int DOUT_W      = 24,
  parameter  int FIR_LATENCY = 8,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int CNT_W       = $clog2(FIR_LATENCY + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       ch_valid,
  output logic [NUM_CH-1:0]       ch_ready,
  input  logic [NUM_CH*DIN_W-1:0] ch_data,
  output logic                    fir_tvalid,
  input  logic                    fir_tready,
  output logic [DIN_W-1:0]        fir_tdata,
  input  logic [DOUT_W-1:0]       fir_result,
  output logic                    out_valid,
  output logic [CH_W-1:0]         out_ch,
  output logic [DOUT_W-1:0]       out_data,
  output logic [CNT_W-1:0]        in_flight
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } hold_state_e;

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  hold_state_e     state_q, state_d;
  logic [CH_W-1:0] last_grant_q;
  logic [CH_W-1:0] fir_ch_q;
  logic [CH_W-1:0] grant_idx;
  logic [CH_W-1:0] probe;
  logic            grant_found;
  logic            load_en;
  logic            grant;
  logic            accept;

  logic            tag_v_q  [FIR_LATENCY];
  logic [CH_W-1:0] tag_ch_q [FIR_LATENCY];

  assign fir_tvalid = (state_q == FULL);
  assign load_en    = !fir_tvalid || fir_tready;
  assign accept     = fir_tvalid && fir_tready;
  assign grant      = load_en && grant_found && !rst;

  // Search starts one past the last winner and wraps, so every requester is reached within NUM_CH grants.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no path can infer a latch.
    grant_found = 1'b0;
    grant_idx   = '0;
    probe       = (last_grant_q == LAST_CH) ? '0 : last_grant_q + CH_W'(1);
    for (int i = 0; i < NUM_CH; i++) begin
      if (!grant_found && ch_valid[probe]) begin
        grant_found = 1'b1;
        grant_idx   = probe;
      end
      probe = (probe == LAST_CH) ? '0 : probe + CH_W'(1);
    end
  end

  always_comb begin
    ch_ready = '0;
    if (grant) ch_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (grant) state_d = FULL;
      FULL:  if (!grant && fir_tready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values, independent of block order.
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // Holding register only moves on a grant, which keeps tdata stable under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      fir_tdata    <= '0;
      fir_ch_q     <= '0;
      last_grant_q <= LAST_CH;
    end else if (grant) begin
      fir_tdata    <= ch_data[int'(grant_idx)*DIN_W +: DIN_W];
      fir_ch_q     <= grant_idx;
      last_grant_q <= grant_idx;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: this line is cleared on reset (unlike a RAM) because stale valid bits would emit ghost results.
    if (rst) begin
      for (int i = 0; i < FIR_LATENCY; i++) begin
        tag_v_q[i]  <= 1'b0;
        tag_ch_q[i] <= '0;
      end
    end else begin
      tag_v_q[0]  <= accept;
      tag_ch_q[0] <= fir_ch_q;
      for (int i = 1; i < FIR_LATENCY; i++) begin
        tag_v_q[i]  <= tag_v_q[i-1];
        tag_ch_q[i] <= tag_ch_q[i-1];
      end
    end
  end

  assign out_valid = tag_v_q[FIR_LATENCY-1];
  assign out_ch    = (NUM_CH > 1) ? tag_ch_q[FIR_LATENCY-1] : '0;
  assign out_data  = fir_result;

  always_ff @(posedge clk) begin
    if (rst) begin
      in_flight <= '0;
    end else begin
      unique case ({accept, out_valid})
        2'b10:   in_flight <= in_flight + CNT_W'(1);
        2'b01:   in_flight <= in_flight - CNT_W'(1);
        default: in_flight <= in_flight;
      endcase
    end
  end

endmodule

// File: doc/fir_rr_scheduler.md
Name: fir_rr_scheduler

Overview:
Shares one FIR compiler instance (AXI-stream slave input, unflagged output) between NUM_CH sample sources. Round-robin arbitrates per-channel valid/ready requests into a single-entry output register that drives the FIR s_axis port. Tags each accepted beat with its channel and delays the tag by the FIR's fixed latency, so each FIR result leaves the block with a channel ID. Sits between the per-channel sample producers and the FIR wrapper.

Parameters:
NUM_CH, 4, number of requesting channels (>=1)
DIN_W, 16, sample width into FIR
DOUT_W, 24, FIR result width
FIR_LATENCY, 8, cycles from accepted FIR input beat to its result on fir_result (>=1)

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock domain, synchronous to clk, active-high
ch_valid  in  NUM_CH  per-channel sample valid
ch_ready  out  NUM_CH  per-channel accept (one-hot or zero)
ch_data  in  NUM_CH*DIN_W  packed samples, channel i at [i*DIN_W +: DIN_W]
fir_tvalid  out  1  to FIR s_axis_data_tvalid
fir_tready  in  1  from FIR s_axis_data_tready
fir_tdata  out  DIN_W  to FIR s_axis_data_tdata
fir_result  in  DOUT_W  from FIR m_axis_data_tdata
out_valid  out  1  fir_result valid this cycle
out_ch  out  max(1,$clog2(NUM_CH))  channel of current result
out_data  out  DOUT_W  result (combinational pass of fir_result)
in_flight  out  $clog2(FIR_LATENCY+1)  beats accepted by FIR but not yet emitted

Behaviour:
- Reset (rst high at a clk edge): fir_tvalid=0, fir_tdata=0, RR pointer set so channel 0 wins first, tag line cleared, out_valid=0, out_ch=0, in_flight=0. ch_ready is 0 while rst is high.
- Holding register states: EMPTY (fir_tvalid=0) and FULL (fir_tvalid=1).
- load_en = !fir_tvalid || fir_tready. A grant occurs only when load_en=1 and some ch_valid=1.
- Arbitration: search from (last_grant+1) mod NUM_CH upward with wrap. The first channel with ch_valid=1 gets ch_ready=1 in that cycle (combinational). last_grant updates only on a grant.
- On grant: at the next edge, fir_tdata<=ch_data[g] and fir_tvalid<=1 (FULL).
- On fir_tvalid&&fir_tready without a grant: fir_tvalid<=0 (EMPTY).
- Accept and grant in the same cycle: the register reloads, fir_tvalid stays 1. Throughput is 1 beat/cycle.
- AXI rule: while FULL and fir_tready=0, fir_tvalid and fir_tdata stay stable and no ch_ready asserts.
- ch_valid must not depend on ch_ready. A channel holding ch_valid without ch_ready keeps its data.
- Tag line: FIR_LATENCY-deep shift register of {v, ch}, shifting every cycle. Stage 0 loads {fir_tvalid&&fir_tready, current fir channel tag}. A beat accepted at edge T yields out_valid=1, out_ch=tag during cycle T+FIR_LATENCY. out_data=fir_result always; meaningful only when out_valid=1.
- in_flight: +1 on accept, -1 when out_valid; both in one cycle gives no change. It never exceeds FIR_LATENCY.
- Reset mid-operation: the holding beat and all tags are discarded. The FIR has no reset, so results of discarded beats appear on fir_result with out_valid=0 and are ignored.
- NUM_CH=1: the arbiter degenerates to a pass-through, and out_ch is held at 0.

Test Plan:
- Single beat: FIR_LATENCY=8, fir_tready=1, ch_valid[2] with 0x1234 for one cycle at cycle 10. Required: ch_ready[2]=1 at 10; fir_tvalid=1 and fir_tdata=0x1234 during 11; FIR accepts at the edge ending 11; out_valid=1 with out_ch=2 during exactly cycle 19; in_flight=1 during cycles 12..19 and 0 at 20.
- Saturation: all 4 channels valid continuously, fir_tready=1, after reset. Required: grants 0,1,2,3,0,1 on consecutive cycles; fir_tvalid never drops; out_ch repeats 0,1,2,3 with out_valid high every cycle once the pipeline fills; in_flight holds at 8.
- Backpressure: FULL with 0x00AA, fir_tready=0 for 5 cycles while channels request. Required: fir_tvalid=1 and fir_tdata=0x00AA stable, ch_ready=0, no tag inserted. When fir_tready returns, accept and reload in the same cycle.
- Sparse RR: only ch_valid[1] and ch_valid[3] held high, fir_tready=1. Required: grant order 1,3,1,3; channels 0 and 2 never readied.
- Alternating ready: fir_tready toggles 1,0,1,0 with channel 0 always valid. Required: exactly one beat accepted per tready=1 cycle, data order preserved, out_valid pattern mirrors the accept pattern delayed 8 cycles.
- Reset with 3 beats in flight and FULL: rst for 1 cycle. Required: next cycle fir_tvalid=0, in_flight=0, out_valid=0 for the following 8 cycles; the first post-reset grant goes to channel 0 when all channels request.
